// File: rtl/vend_pkg.sv
// Shared vending definitions.
//   - Coin codes exchanged between the vending FSM and the change dispenser.
//   - Dispenser fault codes reported on fault_code.
//   - Dispenser FSM state enum and hopper selection type.
//   - code_to_units: converts a change code to 5-rs units owed.
package vend_pkg;

  // Change / coin codes (2-bit, shared with the vending FSM).
  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_5    = 2'b01;
  localparam logic [1:0] CODE_10   = 2'b10;
  localparam logic [1:0] CODE_15   = 2'b11;

  // Dispenser fault codes.
  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_EMPTY   = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT = 2'b10;
  localparam logic [1:0] FLT_WRONG   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_DRIVE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } dispenser_state_e;

  typedef enum logic {
    COIN_5  = 1'b0,
    COIN_10 = 1'b1
  } coin_sel_e;

  // Change owed in 5-rs units for a request code.
  function automatic logic [1:0] code_to_units(input logic [1:0] code);
    logic [1:0] units;
    case (code)
      CODE_5:  units = 2'd1;
      CODE_10: units = 2'd2;
      CODE_15: units = 2'd3;
      default: units = 2'd0;
    endcase
    return units;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// Drive/acknowledge timer for the change dispenser.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : (re)start counting; the following cycle has count 0
//   clear       : stop and zero the counter (start has priority)
//   pulse_done  : high in the last cycle of the PULSE_CYCLES drive window
//   timeout     : high in the cycle in which TIMEOUT_CYCLES cycles have
//                 elapsed since the first counted cycle
module dispense_timer #(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic pulse_done,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic          running_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else if (start) begin
      count_q   <= '0;
      running_q <= 1'b1;
    end else if (clear) begin
      count_q   <= '0;
      running_q <= 1'b0;
    end else if (running_q && (count_q != TIMEOUT_LAST)) begin
      // Saturates at the timeout value until the owner clears it.
      count_q <= count_q + CW'(1);
    end
  end

  assign pulse_done = running_q && (count_q == PULSE_LAST);
  assign timeout    = running_q && (count_q == TIMEOUT_LAST);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a change request one coin at a time from the
// 5-rs and 10-rs hoppers, waiting for the exit-sensor acknowledge after each
// drive, and reports completion or a sticky fault.
//
// Request handshake: a request transfers in any cycle where chg_valid and
// chg_ready are both high. chg_ready is high only in IDLE; the requester must
// hold chg_valid/chg_code stable until the transfer. A CODE_NONE request is
// consumed without any further action.
//
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   chg_valid/chg_code        : change request (vend_pkg CODE_*)
//   chg_ready                 : idle, request can be accepted
//   hop5_empty/hop10_empty    : hopper empty flags
//   hop5_drive/hop10_drive    : hopper motor drives
//   coin5_seen/coin10_seen    : exit-sensor pulses, one per coin
//   done                      : one-cycle pulse, request fully paid
//   fault/fault_code          : sticky fault flag and cause (vend_pkg FLT_*)
//   owed_units                : remaining change in 5-rs units
//   fault_clr                 : clear fault, return to IDLE
//   dbg_state                 : current FSM state
module change_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chg_valid,
  input  logic [1:0]       chg_code,
  output logic             chg_ready,
  input  logic             hop5_empty,
  input  logic             hop10_empty,
  output logic             hop5_drive,
  output logic             hop10_drive,
  input  logic             coin5_seen,
  input  logic             coin10_seen,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [1:0]       owed_units,
  input  logic             fault_clr,
  output dispenser_state_e dbg_state
);

  dispenser_state_e state_q, state_d;
  logic [1:0]       remaining_q, remaining_d;
  coin_sel_e        coin_q, coin_d;
  logic [1:0]       fault_code_q, fault_code_d;

  logic timer_start;
  logic timer_clear;
  logic pulse_done;
  logic timeout;

  logic       match_seen;
  logic       other_seen;
  logic [1:0] coin_units;

  // The sensor for the coin being paid is "match"; the other one is a wrong
  // coin. Both at once is also treated as a wrong coin.
  assign match_seen = (coin_q == COIN_10) ? coin10_seen : coin5_seen;
  assign other_seen = (coin_q == COIN_10) ? coin5_seen  : coin10_seen;
  assign coin_units = (coin_q == COIN_10) ? 2'd2 : 2'd1;

  // Timer runs only while a coin is in flight.
  assign timer_clear = (state_q != ST_DRIVE) && (state_q != ST_WAIT);

  dispense_timer #(
    .PULSE_CYCLES  (PULSE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (timer_start),
    .clear     (timer_clear),
    .pulse_done(pulse_done),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= 2'd0;
      coin_q       <= COIN_5;
      fault_code_q <= FLT_NONE;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      coin_q       <= coin_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    coin_d       = coin_q;
    fault_code_d = fault_code_q;
    timer_start  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (chg_valid && (chg_code != CODE_NONE)) begin
          remaining_d = code_to_units(chg_code);
          state_d     = ST_SELECT;
        end
      end

      ST_SELECT: begin
        // Largest coin that does not overpay; never substitute a 10 for a 5.
        if (remaining_q == 2'd0) begin
          state_d = ST_DONE;
        end else if ((remaining_q >= 2'd2) && !hop10_empty) begin
          coin_d      = COIN_10;
          timer_start = 1'b1;
          state_d     = ST_DRIVE;
        end else if (!hop5_empty) begin
          coin_d      = COIN_5;
          timer_start = 1'b1;
          state_d     = ST_DRIVE;
        end else begin
          fault_code_d = FLT_EMPTY;
          state_d      = ST_FAULT;
        end
      end

      ST_DRIVE, ST_WAIT: begin
        // An acknowledge takes priority over the drive window ending or the
        // timer expiring in the same cycle.
        if (other_seen) begin
          fault_code_d = FLT_WRONG;
          state_d      = ST_FAULT;
        end else if (match_seen) begin
          remaining_d = remaining_q - coin_units;
          state_d     = ST_SELECT;
        end else if (timeout) begin
          fault_code_d = FLT_TIMEOUT;
          state_d      = ST_FAULT;
        end else if ((state_q == ST_DRIVE) && pulse_done) begin
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        if (fault_clr) begin
          remaining_d  = 2'd0;
          fault_code_d = FLT_NONE;
          state_d      = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All outputs decode registered state only.
  assign chg_ready   = (state_q == ST_IDLE);
  assign hop5_drive  = (state_q == ST_DRIVE) && (coin_q == COIN_5);
  assign hop10_drive = (state_q == ST_DRIVE) && (coin_q == COIN_10);
  assign done        = (state_q == ST_DONE);
  assign fault       = (state_q == ST_FAULT);
  assign fault_code  = fault_code_q;
  assign owed_units  = remaining_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser. Events (drive pulses with start cycle and width,
// done, fault rise) are collected each cycle and matched against an expected
// queue; cycles are counted from the cycle the request is accepted (cycle 0).
module tb_change_dispenser;
  import vend_pkg::*;

  localparam int P = 4;
  localparam int T = 20;

  localparam logic [3:0] K_D5    = 4'd1;
  localparam logic [3:0] K_D10   = 4'd2;
  localparam logic [3:0] K_DONE  = 4'd3;
  localparam logic [3:0] K_FAULT = 4'd4;

  localparam int ACK_NONE  = 0;
  localparam int ACK_AUTO  = 1;
  localparam int ACK_WRONG = 2;
  localparam int ACK_BOTH  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             chg_valid;
  logic [1:0]       chg_code;
  logic             chg_ready;
  logic             hop5_empty, hop10_empty;
  logic             hop5_drive, hop10_drive;
  logic             coin5_seen, coin10_seen;
  logic             done, fault;
  logic [1:0]       fault_code, owed_units;
  logic             fault_clr;
  dispenser_state_e dbg_state;

  change_dispenser #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chg_valid  (chg_valid),
    .chg_code   (chg_code),
    .chg_ready  (chg_ready),
    .hop5_empty (hop5_empty),
    .hop10_empty(hop10_empty),
    .hop5_drive (hop5_drive),
    .hop10_drive(hop10_drive),
    .coin5_seen (coin5_seen),
    .coin10_seen(coin10_seen),
    .done       (done),
    .fault      (fault),
    .fault_code (fault_code),
    .owed_units (owed_units),
    .fault_clr  (fault_clr),
    .dbg_state  (dbg_state)
  );

  // ---------------- bench state ----------------
  int checks;
  int failures;
  int cyc;
  int t0;
  int ack_mode;
  int ack_delay;
  int pend_cnt;
  int pend_kind;  // 0: coin5, 1: coin10, 2: both
  logic prev5, prev10, prevf;
  int s5, s10, w5, w10;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] ev_drive(input logic [3:0] k, input int w, input int s);
    logic [15:0] r;
    r = {k, w[3:0], s[7:0]};
    return r;
  endfunction

  function automatic logic [15:0] ev_fault(input logic [1:0] c, input logic [1:0] o, input int s);
    logic [15:0] r;
    r = {K_FAULT, c, o, s[7:0]};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle: monitor DUT outputs, run the hopper sensor model,
  // then match observed events against the expected queue.
  task automatic tick();
    logic [15:0] act_q[$];
    logic [15:0] a, e;
    int rel;
    @(negedge clk);
    cyc++;
    rel = cyc - t0;

    if (hop5_drive === 1'b1) begin
      if (!prev5) s5 = rel;
      w5++;
    end else if (prev5) begin
      act_q.push_back(ev_drive(K_D5, w5, s5));
      w5 = 0;
      if (ack_mode == ACK_AUTO || ack_mode == ACK_BOTH) begin
        pend_cnt  = ack_delay + 1;
        pend_kind = (ack_mode == ACK_BOTH) ? 2 : 0;
      end
    end
    if (hop10_drive === 1'b1) begin
      if (!prev10) s10 = rel;
      w10++;
    end else if (prev10) begin
      act_q.push_back(ev_drive(K_D10, w10, s10));
      w10 = 0;
      if (ack_mode == ACK_AUTO || ack_mode == ACK_BOTH) begin
        pend_cnt  = ack_delay + 1;
        pend_kind = (ack_mode == ACK_BOTH) ? 2 : 1;
      end
    end
    if (done === 1'b1) act_q.push_back(ev_drive(K_DONE, 0, rel));
    if (fault === 1'b1 && !prevf) act_q.push_back(ev_fault(fault_code, owed_units, rel));
    prev5  = (hop5_drive === 1'b1);
    prev10 = (hop10_drive === 1'b1);
    prevf  = (fault === 1'b1);

    // Hopper sensor model.
    coin5_seen  = 1'b0;
    coin10_seen = 1'b0;
    if (ack_mode == ACK_WRONG && hop10_drive === 1'b1 && w10 == 2) coin5_seen = 1'b1;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        coin5_seen  = (pend_kind != 1);
        coin10_seen = (pend_kind != 0);
      end
    end

    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_event: got %h, required no event (cycle %0d)", a, rel);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL sb_event: got %h, required %h (cycle %0d)", a, e, rel);
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the bench in cycle 1 (SELECT) of the request.
  task automatic request(input logic [1:0] code);
    tick();
    chg_valid = 1'b1;
    chg_code  = code;
    t0        = cyc;
    tick();
    chg_valid = 1'b0;
    chg_code  = CODE_NONE;
  endtask

  task automatic clear_fault();
    tick();
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  // Expected events for a request paid from the current hopper flags, each
  // coin acknowledged ack_delay cycles after its drive window ends.
  task automatic push_paid(input logic [1:0] code, output int done_rel);
    int units, rel;
    units = int'(code);
    rel   = 2;
    while (units > 0) begin
      if (units >= 2 && !hop10_empty) begin
        exp_q.push_back(ev_drive(K_D10, P, rel));
        units -= 2;
      end else begin
        exp_q.push_back(ev_drive(K_D5, P, rel));
        units -= 1;
      end
      rel += P + ack_delay + 2;
    end
    exp_q.push_back(ev_drive(K_DONE, 0, rel));
    done_rel = rel;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    run(2);
    checks++;
    if ({chg_ready, hop5_drive, hop10_drive, done, fault} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: got %b, required 10000", {chg_ready, hop5_drive, hop10_drive, done, fault});
    end
    checks++;
    if ({fault_code, owed_units} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_codes: got %b, required 0000", {fault_code, owed_units});
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_paid(input string name, input logic [1:0] code, input logic e5, input logic e10);
    int dr;
    hop5_empty  = e5;
    hop10_empty = e10;
    ack_mode    = ACK_AUTO;
    ack_delay   = 0;
    push_paid(code, dr);
    request(code);
    run(dr + 1);
    checks++;
    if (exp_q.size() != 0 || chg_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_end: got pending=%0d ready=%b, required pending=0 ready=1", name, exp_q.size(), chg_ready);
    end
    exp_q.delete();
    hop5_empty  = 1'b0;
    hop10_empty = 1'b0;
  endtask

  task automatic test_empty_fault();
    hop5_empty  = 1'b1;
    hop10_empty = 1'b0;
    ack_mode    = ACK_AUTO;
    exp_q.push_back(ev_fault(FLT_EMPTY, 2'd1, 2));
    request(CODE_5);
    run(5);
    checks++;
    if ({fault, fault_code, owed_units, hop5_drive, hop10_drive, chg_ready} !== 8'b1_01_01_000) begin
      failures++;
      $display("FAIL empty_fault: got %b, required 10101000", {fault, fault_code, owed_units, hop5_drive, hop10_drive, chg_ready});
    end
    clear_fault();
    checks++;
    if ({chg_ready, fault, fault_code, owed_units} !== 6'b100000) begin
      failures++;
      $display("FAIL empty_clear: got %b, required 100000", {chg_ready, fault, fault_code, owed_units});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL empty_pending: got %0d, required 0", exp_q.size());
    end
    exp_q.delete();
    hop5_empty = 1'b0;
  endtask

  task automatic test_timeout();
    ack_mode = ACK_NONE;
    exp_q.push_back(ev_drive(K_D10, P, 2));
    exp_q.push_back(ev_fault(FLT_TIMEOUT, 2'd2, 2 + T));
    request(CODE_10);
    run(T + 3);
    checks++;
    if ({fault, fault_code, owed_units, hop5_drive, hop10_drive, chg_ready} !== 8'b1_10_10_000) begin
      failures++;
      $display("FAIL timeout_fault: got %b, required 11010000", {fault, fault_code, owed_units, hop5_drive, hop10_drive, chg_ready});
    end
    // A request while faulted is ignored.
    chg_valid = 1'b1;
    chg_code  = CODE_5;
    run(3);
    chg_valid = 1'b0;
    chg_code  = CODE_NONE;
    checks++;
    if (dbg_state !== ST_FAULT || owed_units !== 2'd2 || fault_code !== FLT_TIMEOUT) begin
      failures++;
      $display("FAIL timeout_hold: got state=%0d owed=%0d code=%0d, required state=%0d owed=2 code=2",
               dbg_state, owed_units, fault_code, ST_FAULT);
    end
    clear_fault();
    checks++;
    if ({chg_ready, fault, fault_code, owed_units} !== 6'b100000) begin
      failures++;
      $display("FAIL timeout_clear: got %b, required 100000", {chg_ready, fault, fault_code, owed_units});
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_pending: got %0d, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_drive();
    ack_mode = ACK_NONE;
    exp_q.push_back(ev_drive(K_D5, 2, 2));
    request(CODE_5);
    run(2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hop5_drive, hop10_drive, chg_ready} !== 3'b001 || dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_mid_drive: got drives/ready=%b state=%0d, required 001 state=%0d",
               {hop5_drive, hop10_drive, chg_ready}, dbg_state, ST_IDLE);
    end
    tick();
    rst_n = 1'b1;
    run(2);
    checks++;
    if (chg_ready !== 1'b1 || dbg_state !== ST_IDLE || hop5_drive !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b state=%0d drive5=%b pending=%0d, required 1 %0d 0 0",
               chg_ready, dbg_state, hop5_drive, exp_q.size(), ST_IDLE);
    end
    exp_q.delete();
  endtask

  task automatic test_wrong_coin();
    // 5-rs pulse while the 10-rs hopper is driving.
    ack_mode = ACK_WRONG;
    exp_q.push_back(ev_drive(K_D10, 2, 2));
    exp_q.push_back(ev_fault(FLT_WRONG, 2'd2, 4));
    request(CODE_10);
    run(5);
    checks++;
    if ({fault, fault_code, owed_units} !== 5'b1_11_10) begin
      failures++;
      $display("FAIL wrong_coin: got %b, required 11110", {fault, fault_code, owed_units});
    end
    clear_fault();
    // Both sensors at once while waiting on a 5-rs coin.
    ack_mode  = ACK_BOTH;
    ack_delay = 0;
    exp_q.push_back(ev_drive(K_D5, P, 2));
    exp_q.push_back(ev_fault(FLT_WRONG, 2'd1, 7));
    request(CODE_5);
    run(8);
    checks++;
    if ({fault, fault_code, owed_units} !== 5'b1_11_01) begin
      failures++;
      $display("FAIL both_sensors: got %b, required 11101", {fault, fault_code, owed_units});
    end
    clear_fault();
    checks++;
    if (exp_q.size() != 0 || chg_ready !== 1'b1) begin
      failures++;
      $display("FAIL wrong_end: got pending=%0d ready=%b, required 0 1", exp_q.size(), chg_ready);
    end
    exp_q.delete();
  endtask

  task automatic test_zero_code();
    ack_mode = ACK_AUTO;
    tick();
    chg_valid = 1'b1;
    chg_code  = CODE_NONE;
    t0        = cyc;
    tick();
    chg_valid = 1'b0;
    run(4);
    checks++;
    if (chg_ready !== 1'b1 || dbg_state !== ST_IDLE || exp_q.size() != 0) begin
      failures++;
      $display("FAIL zero_code: got ready=%b state=%0d, required ready=1 state=%0d", chg_ready, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int dr;
    logic [1:0] code;
    ack_mode = ACK_AUTO;
    for (int i = 0; i < 4; i++) begin
      code      = 2'($urandom_range(1, 3));
      ack_delay = $urandom_range(0, 10);
      push_paid(code, dr);
      request(code);
      run(dr - 1);
      checks++;
      if (done !== 1'b1) begin
        failures++;
        $display("FAIL b2b_done: got %b, required 1 (code %0d delay %0d)", done, code, ack_delay);
      end
    end
    run(2);
    checks++;
    if (exp_q.size() != 0 || chg_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: got pending=%0d ready=%b, required 0 1", exp_q.size(), chg_ready);
    end
    exp_q.delete();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    t0          = 0;
    ack_mode    = ACK_NONE;
    ack_delay   = 0;
    pend_cnt    = 0;
    pend_kind   = 0;
    prev5       = 1'b0;
    prev10      = 1'b0;
    prevf       = 1'b0;
    s5          = 0;
    s10         = 0;
    w5          = 0;
    w10         = 0;
    rst_n       = 1'b0;
    chg_valid   = 1'b0;
    chg_code    = CODE_NONE;
    hop5_empty  = 1'b0;
    hop10_empty = 1'b0;
    coin5_seen  = 1'b0;
    coin10_seen = 1'b0;
    fault_clr   = 1'b0;

    test_reset();
    test_paid("single5", CODE_5, 1'b0, 1'b0);
    test_paid("fifteen", CODE_15, 1'b0, 1'b0);
    test_paid("ten_no10", CODE_10, 1'b0, 1'b1);
    test_empty_fault();
    test_timeout();
    test_reset_mid_drive();
    test_wrong_coin();
    test_zero_code();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Pays out change coins after a vend. It accepts a change request in the vend FSM's 2-bit coin code and drives the 5-rs and 10-rs coin hoppers one coin at a time. After each drive it waits for the hopper exit-sensor acknowledge, and reports completion or a sticky fault. It sits downstream of the vending FSM's `change` output, between it and the hopper hardware.

## Interface
- `PULSE_CYCLES`, default 4: hopper drive pulse width in clocks (≥1).
- `TIMEOUT_CYCLES`, default 1000: clocks from drive start to missing-coin fault (> `PULSE_CYCLES`).
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `chg_valid` input 1: change request present.
- `chg_code` input 2: requested change; 00 = none, 01 = 5 rs, 10 = 10 rs, 11 = 15 rs.
- `chg_ready` output 1: block is idle and can accept a request.
- `hop5_empty`, `hop10_empty` input 1 each: hopper empty flags.
- `hop5_drive`, `hop10_drive` output 1 each: hopper motor drive.
- `coin5_seen`, `coin10_seen` input 1 each: exit sensor, one-cycle pulse per coin, synchronous to `clk`.
- `done` output 1: one-cycle pulse when a request is fully paid.
- `fault` output 1: sticky fault flag.
- `fault_code` output 2: 00 none, 01 hopper empty, 10 jam/timeout, 11 wrong coin.
- `owed_units` output 2: remaining change in 5-rs units; valid while `fault`=1.
- `fault_clr` input 1: clears the fault and returns the block to IDLE.

## Operation
- States: IDLE, SELECT, DRIVE, WAIT, DONE, FAULT.
- IDLE: `chg_ready`=1. When `chg_valid` is high, load `remaining` from `chg_code` (01→1, 10→2, 11→3 units).
  - A code of 00 is consumed with no action; the block stays in IDLE and `done` does not pulse.
  - A nonzero code moves the block to SELECT.
- SELECT: one cycle. Checks run in this priority order:
  1. `remaining`=0 → DONE.
  2. `remaining`≥2 and `!hop10_empty` → coin=10, go to DRIVE.
  3. `!hop5_empty` → coin=5, go to DRIVE.
  4. Otherwise → FAULT with code 01.
  - The block never overpays: with 1 unit owed and the 5-rs hopper empty, it faults even if the 10-rs hopper is full.
- DRIVE: the selected `hopX_drive`=1 for exactly `PULSE_CYCLES` cycles, then the block moves to WAIT. The timer starts on the first DRIVE cycle.
- Sensor acceptance during DRIVE and WAIT:
  - A matching sensor pulse decrements `remaining` by the coin's units (10→2, 5→1) and returns the block to SELECT. If the pulse arrives in DRIVE, the drive ends early.
  - A non-matching sensor pulse → FAULT code 11.
  - Timer reaching `TIMEOUT_CYCLES` with no pulse → FAULT code 10.
  - If both sensors pulse in the same cycle, it is treated as a wrong coin (11).
- DONE: `done`=1 for one cycle, then IDLE.
- FAULT: `fault`=1. `fault_code` and `owed_units`=`remaining` are held and both drives are 0.
  - `fault_clr` → IDLE with `remaining`, `fault_code` and `fault` cleared.
  - `chg_valid` is ignored while faulted.
- Sensor pulses in IDLE, SELECT, DONE or FAULT are ignored.
- Reset, including mid-dispense, forces IDLE immediately and asynchronously. Reset values:
  - `chg_ready`=1.
  - `hop5_drive`, `hop10_drive`, `done`, `fault` = 0.
  - `fault_code`=00, `owed_units`=0.
  - Timer and `remaining` = 0.

## Timing
- Cycle 0: request accepted in IDLE. Cycle 1: SELECT. Cycle 2: first drive cycle.
- Sensor pulse in cycle k → SELECT in cycle k+1. The next drive starts at k+2, or `done` pulses at k+2.
- Single-coin request with the ack in the cycle after the drive ends: `done` at cycle 2+`PULSE_CYCLES`+2.
- Timeout fires when `TIMEOUT_CYCLES` cycles have elapsed counting from the first drive cycle. `fault` is visible the following cycle.
- All outputs are decoded from registered state and counters; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `vend_pkg` holds:
  - coin code constants (`CODE_NONE`, `CODE_5`, `CODE_10`, `CODE_15`), shared with the vending FSM;
  - fault code constants;
  - the dispenser state enum.
- One sub-module, `dispense_timer`: loadable up-counter with `start`, `clear`, `pulse_done` (at `PULSE_CYCLES`) and `timeout` (at `TIMEOUT_CYCLES`) outputs.

## Test plan
All scenarios use `PULSE_CYCLES`=4 and `TIMEOUT_CYCLES`=20.
- `chg_code`=01, both hoppers full, `coin5_seen` 1 cycle after drive ends → `hop5_drive` high cycles 2–5, `done` at cycle 8, `hop10_drive` never high.
- `chg_code`=11, both hoppers full, each coin acked promptly → one 10-rs drive, then one 5-rs drive, then a single `done`.
- `chg_code`=10, `hop10_empty`=1 → two consecutive 5-rs dispenses, then `done`.
- `chg_code`=01, `hop5_empty`=1, `hop10_empty`=0 → `fault`=1, `fault_code`=01, `owed_units`=1, no drive ever.
- `chg_code`=10, no sensor pulse → `fault_code`=10 after 20 cycles, `owed_units`=2; `fault_clr` → `chg_ready`=1.
- `rst_n` asserted in the middle of a drive → drive drops to 0 immediately, IDLE on release. Separately, `coin5_seen` during a 10-rs drive → `fault_code`=11.
